ram_arbiter: RTL and testbench

- Shares the single data RAM between two requesters: instruction fetch (IF, read-only word) and execute-stage load/store (LS, read/write, byte/half/word).
- Registers the winning request and sequences the RAM's one-cycle-latency read.
- Sign- or zero-extends load data and raises a pipeline hold while a load/store is pending.
- Sits between the fetch unit, the execute stage and the ram instance.

---
 rtl/ram_pkg.sv | 26 ++
 rtl/load_ext.sv | 24 ++
 rtl/ram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared encodings for the RAM arbiter: access sizes, FSM states and requester ids.
package ram_pkg;

    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

    // Wide enough for LS_BURST_MAX up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        ID_IF = 1'b0,
        ID_LS = 1'b1
    } req_id_e;

    function automatic logic size_valid(input logic [2:0] size);
        return size inside {SZ_B, SZ_H, SZ_W};
    endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational sign/zero extension of a RAM read word to the requested load size.
module load_ext
    import ram_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [2:0]        size_i,
    input  logic              sext_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives data_o and no latch is inferred.
        data_o = '0;
        case (size_i)
            SZ_B:    data_o = {{(DATA_W-8){sext_i & word_i[7]}}, word_i[7:0]};
            SZ_H:    data_o = {{(DATA_W-16){sext_i & word_i[15]}}, word_i[15:0]};
            SZ_W:    data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single data RAM between instruction fetch and load/store, with a
// bounded LS burst so a waiting fetch is never starved.
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LS_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [2:0]        ls_size_i,
    input  logic              ls_sext_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_ack_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              hold_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_rd_en_o,
    output logic              ram_wd_en_o,
    output logic [2:0]        ram_size_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    state_e            state_q, state_d;
    req_id_e           id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              sext_q, sext_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  fair_q, fair_d;

    logic              at_max, pick_ls, ls_win, if_win;
    logic [DATA_W-1:0] ext_data;

    load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .word_i (ram_rdata_i),
        .size_i (size_q),
        .sext_i (sext_q),
        .data_o (ext_data)
    );

    // LS wins by default; IF takes over once LS has had LS_BURST_MAX grants in a row.
    assign at_max  = (fair_q == CNT_W'(LS_BURST_MAX));
    assign pick_ls = ls_req_i && !(if_req_i && at_max);
    assign ls_win  = (state_q == IDLE) && pick_ls;
    assign if_win  = (state_q == IDLE) && if_req_i && !pick_ls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every latched field is reset so nothing from an aborted access survives.
            state_q <= IDLE;
            id_q    <= ID_IF;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            wdata_q <= '0;
            fair_q  <= '0;
        end else begin
            // NOTE: non-blocking so all registers update together from pre-edge values.
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            sext_q  <= sext_d;
            wdata_q <= wdata_d;
            fair_q  <= fair_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        sext_d  = sext_q;
        wdata_d = wdata_q;
        fair_d  = fair_q;
        case (state_q)
            IDLE: begin
                if (ls_win) begin
                    id_d    = ID_LS;
                    addr_d  = ls_addr_i;
                    size_d  = ls_size_i;
                    we_d    = ls_we_i;
                    sext_d  = ls_sext_i;
                    wdata_d = ls_wdata_i;
                    fair_d  = !if_req_i ? '0 : (at_max ? fair_q : fair_q + CNT_W'(1));
                    state_d = ISSUE;
                end else if (if_win) begin
                    id_d    = ID_IF;
                    addr_d  = if_addr_i;
                    size_d  = SZ_W;
                    we_d    = 1'b0;
                    sext_d  = 1'b0;
                    wdata_d = '0;
                    fair_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        ls_ack_o    = 1'b0;
        ls_rvalid_o = 1'b0;
        ls_rdata_o  = '0;
        hold_o      = 1'b0;
        ram_addr_o  = '0;
        ram_rd_en_o = 1'b0;
        ram_wd_en_o = 1'b0;
        ram_size_o  = '0;
        ram_wdata_o = '0;
        // Outputs derived from live inputs must also read 0 during reset.
        if (!rst) begin
            if_gnt_o = if_win;
            ls_gnt_o = ls_win;
            hold_o   = ls_req_i || ((id_q == ID_LS) && (state_q != IDLE));
            case (state_q)
                ISSUE: begin
                    ram_addr_o  = addr_q;
                    ram_size_o  = size_q;
                    ram_wdata_o = wdata_q;
                    if (we_q) begin
                        ram_wd_en_o = size_valid(size_q);
                        ls_ack_o    = (id_q == ID_LS);
                    end else begin
                        ram_rd_en_o = size_valid(size_q);
                    end
                end
                RESP: begin
                    if (id_q == ID_LS) begin
                        ls_rvalid_o = 1'b1;
                        ls_rdata_o  = ext_data;
                    end else begin
                        if_rvalid_o = 1'b1;
                        if_rdata_o  = ram_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a behavioural RAM plus a scoreboard of expected read
// responses pushed at grant time and popped when an rvalid pulse appears.
module tb_ram_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_i, if_gnt_o, if_rvalid_o;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              ls_req_i, ls_we_i, ls_sext_i;
    logic [2:0]        ls_size_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [DATA_W-1:0] ls_wdata_i;
    logic              ls_gnt_o, ls_ack_o, ls_rvalid_o;
    logic [DATA_W-1:0] ls_rdata_o;
    logic              hold_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_rd_en_o, ram_wd_en_o;
    logic [2:0]        ram_size_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i = '0;

    typedef struct packed {
        logic        is_ls;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem[logic [31:0]];
    int          n_cmp = 0;
    int          n_bad = 0;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LS_BURST_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .ls_req_i    (ls_req_i),
        .ls_we_i     (ls_we_i),
        .ls_size_i   (ls_size_i),
        .ls_sext_i   (ls_sext_i),
        .ls_addr_i   (ls_addr_i),
        .ls_wdata_i  (ls_wdata_i),
        .ls_gnt_o    (ls_gnt_o),
        .ls_ack_o    (ls_ack_o),
        .ls_rvalid_o (ls_rvalid_o),
        .ls_rdata_o  (ls_rdata_o),
        .hold_o      (hold_o),
        .ram_addr_o  (ram_addr_o),
        .ram_rd_en_o (ram_rd_en_o),
        .ram_wd_en_o (ram_wd_en_o),
        .ram_size_o  (ram_size_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM; unread addresses return 0.
    always @(posedge clk) begin
        if (ram_wd_en_o) mem[ram_addr_o] = ram_wdata_o;
        ram_rdata_i <= (ram_rd_en_o && mem.exists(ram_addr_o)) ? mem[ram_addr_o] : '0;
    end

    function automatic logic [31:0] b(input logic x);
        return {31'b0, x};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land on the negedge, retiring any read response.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (if_rvalid_o || ls_rvalid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", {30'b0, if_rvalid_o, ls_rvalid_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rvalid_id", b(ls_rvalid_o), b(e.is_ls));
                check("rvalid_both", b(if_rvalid_o & ls_rvalid_o), 32'd0);
                check("rdata", ls_rvalid_o ? ls_rdata_o : if_rdata_o, e.data);
            end
        end
        if (!if_rvalid_o) check("if_rdata_zero", if_rdata_o, 32'd0);
        if (!ls_rvalid_o) check("ls_rdata_zero", ls_rdata_o, 32'd0);
    endtask

    task automatic ls_access(input string tag, input logic we, input logic [2:0] size,
                             input logic sext, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata_exp);
        logic valid;
        exp_t e;
        valid      = (size == 3'd1) || (size == 3'd2) || (size == 3'd4);
        ls_req_i   = 1'b1;
        ls_we_i    = we;
        ls_size_i  = size;
        ls_sext_i  = sext;
        ls_addr_i  = addr;
        ls_wdata_i = wdata;
        #1;
        check({tag, "_gnt"}, b(ls_gnt_o), 32'd1);
        check({tag, "_hold_req"}, b(hold_o), 32'd1);
        if (!we) begin
            e.is_ls = 1'b1;
            e.data  = rdata_exp;
            exp_q.push_back(e);
        end
        tick();
        ls_req_i = 1'b0;
        #1;
        check({tag, "_rd_en"}, b(ram_rd_en_o), b(!we && valid));
        check({tag, "_wd_en"}, b(ram_wd_en_o), b(we && valid));
        check({tag, "_ack"}, b(ls_ack_o), b(we));
        check({tag, "_addr"}, ram_addr_o, addr);
        check({tag, "_size"}, {29'b0, ram_size_o}, {29'b0, size});
        if (we) check({tag, "_wdata"}, ram_wdata_o, wdata);
        check({tag, "_hold_issue"}, b(hold_o), 32'd1);
        tick();
        if (!we) begin
            check({tag, "_hold_resp"}, b(hold_o), 32'd1);
            tick();
        end
        check({tag, "_hold_idle"}, b(hold_o), 32'd0);
    endtask

    initial begin
        exp_t       e;
        logic [1:0] order [6];
        int         n_gnt;
        int         last_cyc;

        mem[32'h10] = 32'h0000_0013;
        mem[32'h40] = 32'h1234_8001;

        // Reset: requests asserted but every output must read 0.
        rst        = 1'b1;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h10;
        ls_req_i   = 1'b1;
        ls_we_i    = 1'b0;
        ls_size_i  = 3'd4;
        ls_sext_i  = 1'b0;
        ls_addr_i  = '0;
        ls_wdata_i = '0;
        @(negedge clk);
        check("rst_if_gnt", b(if_gnt_o), 32'd0);
        check("rst_ls_gnt", b(ls_gnt_o), 32'd0);
        check("rst_hold", b(hold_o), 32'd0);
        check("rst_rd_en", b(ram_rd_en_o), 32'd0);
        check("rst_rvalid", {30'b0, if_rvalid_o, ls_rvalid_o}, 32'd0);
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        rst      = 1'b0;
        tick();

        // Single IF read: grant N, rd_en N+1, rvalid N+2.
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        #1;
        check("if_gnt", b(if_gnt_o), 32'd1);
        check("if_ls_gnt", b(ls_gnt_o), 32'd0);
        check("if_hold", b(hold_o), 32'd0);
        e.is_ls = 1'b0;
        e.data  = 32'h0000_0013;
        exp_q.push_back(e);
        tick();
        if_req_i = 1'b0;
        #1;
        check("if_rd_en", b(ram_rd_en_o), 32'd1);
        check("if_addr", ram_addr_o, 32'h10);
        check("if_size", {29'b0, ram_size_o}, 32'd4);
        check("if_gnt_issue", b(if_gnt_o), 32'd0);
        tick();
        tick();

        // Loads and stores with extension and invalid sizes.
        ls_access("sb",     1'b1, 3'd1, 1'b0, 32'h20, 32'h80,        '0);
        ls_access("lb",     1'b0, 3'd1, 1'b1, 32'h20, '0,            32'hFFFF_FF80);
        ls_access("lbu",    1'b0, 3'd1, 1'b0, 32'h20, '0,            32'h0000_0080);
        ls_access("lh",     1'b0, 3'd2, 1'b1, 32'h40, '0,            32'hFFFF_8001);
        ls_access("lhu",    1'b0, 3'd2, 1'b0, 32'h40, '0,            32'h0000_8001);
        ls_access("lw",     1'b0, 3'd4, 1'b0, 32'h40, '0,            32'h1234_8001);
        ls_access("sw",     1'b1, 3'd4, 1'b0, 32'h44, 32'hDEAD_BEEF, '0);
        ls_access("ld_bad", 1'b0, 3'd3, 1'b1, 32'h40, '0,            32'h0);
        ls_access("st_bad", 1'b1, 3'd0, 1'b0, 32'h44, 32'h0,         '0);
        ls_access("lw2",    1'b0, 3'd4, 1'b0, 32'h44, '0,            32'hDEAD_BEEF);

        // Contention: LS x4, then IF, then LS; reads space grants 3 cycles apart.
        order     = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
        n_gnt     = 0;
        last_cyc  = 0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_size_i = 3'd4;
        ls_sext_i = 1'b0;
        ls_addr_i = 32'h40;
        #1;
        for (int cyc = 0; cyc < 60 && n_gnt < 6; cyc++) begin
            check("cont_hold", b(hold_o), 32'd1);
            if (if_gnt_o || ls_gnt_o) begin
                check("cont_order", {30'b0, ls_gnt_o, if_gnt_o}, {30'b0, order[n_gnt]});
                if (n_gnt > 0) check("cont_gap", cyc - last_cyc, 32'd3);
                e.is_ls = ls_gnt_o;
                e.data  = ls_gnt_o ? 32'h1234_8001 : 32'h0000_0013;
                exp_q.push_back(e);
                last_cyc = cyc;
                n_gnt++;
            end
            tick();
        end
        check("cont_grants", n_gnt, 32'd6);
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        tick();
        tick();
        tick();

        // Reset during the ISSUE cycle of a load: response is discarded.
        ls_req_i  = 1'b1;
        ls_addr_i = 32'h40;
        #1;
        check("rstm_gnt", b(ls_gnt_o), 32'd1);
        tick();
        ls_req_i = 1'b0;
        if_req_i = 1'b1;
        #1;
        check("rstm_rd_en_pre", b(ram_rd_en_o), 32'd1);
        rst = 1'b1;
        #1;
        check("rstm_rd_en", b(ram_rd_en_o), 32'd0);
        check("rstm_addr", ram_addr_o, 32'd0);
        check("rstm_hold", b(hold_o), 32'd0);
        check("rstm_if_gnt", b(if_gnt_o), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rstm_if_gnt_after", b(if_gnt_o), 32'd1);
        e.is_ls = 1'b0;
        e.data  = 32'h0000_0013;
        exp_q.push_back(e);
        tick();
        if_req_i = 1'b0;
        tick();
        tick();
        tick();

        check("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
